// File: rtl/mem_channel_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_channel_arbiter
// Desc     : Round-robin N-channel arbiter onto one active-low strobed memory
//            port, with per-channel bypass, registered responses and timeout.
// Revision : 1.0 - initial release
// ============================================================================
module mem_channel_arbiter #(
    parameter int CHANNELS   = 3,
    parameter int ADDR_WIDTH = 25,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [CHANNELS*ADDR_WIDTH-1:0] ch_addr,
    input  logic [CHANNELS-1:0]            ch_enable,
    input  logic [CHANNELS-1:0]            ch_write,
    input  logic [CHANNELS*DATA_WIDTH-1:0] ch_wdata,
    input  logic [CHANNELS-1:0]            ch_gate,
    output logic [CHANNELS*DATA_WIDTH-1:0] ch_rdata,
    output logic [CHANNELS-1:0]            ch_valid,
    output logic [CHANNELS-1:0]            ch_error,
    output logic [ADDR_WIDTH-1:0]          mem_address,
    output logic                           mem_read_n,
    output logic                           mem_write_n,
    output logic [DATA_WIDTH-1:0]          mem_write_data,
    input  logic [DATA_WIDTH-1:0]          mem_read_data,
    input  logic                           mem_done_n,
    output logic                           busy
);
    localparam int c_PTR_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int c_CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = (TIMEOUT > 0) ? c_CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [c_PTR_W-1:0] c_PTR_RST  = c_PTR_W'(CHANNELS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [c_PTR_W-1:0]    r_ptr;
    logic [c_PTR_W-1:0]    r_grant;
    logic [c_PTR_W-1:0]    w_grant;
    logic [c_PTR_W-1:0]    w_idx;
    logic                  w_found;
    logic [c_CNT_W-1:0]    r_cnt;
    logic                  r_write;
    logic                  w_done;
    logic                  w_timeout;
    logic [CHANNELS-1:0]   w_cand;
    logic [CHANNELS-1:0]   w_byp_fire;
    logic [CHANNELS-1:0]   r_byp_pend;
    logic [CHANNELS-1:0]   w_busy_mask;
    logic [CHANNELS-1:0]   r_ch_valid;
    logic [CHANNELS-1:0]   r_ch_error;
    logic [DATA_WIDTH-1:0] r_ch_rdata [CHANNELS];
    logic [ADDR_WIDTH-1:0] w_addr     [CHANNELS];
    logic [DATA_WIDTH-1:0] w_wdata    [CHANNELS];
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [ADDR_WIDTH-1:0] r_mem_address;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic                  r_read_n;
    logic                  r_write_n;
    logic                  w_unused_addr_lsb;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            assign w_addr[gi]  = ch_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_wdata[gi] = ch_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
            assign ch_rdata[gi*DATA_WIDTH +: DATA_WIDTH] = r_ch_rdata[gi];
            // The channel owning the memory port must not also complete via bypass.
            assign w_busy_mask[gi] = (r_state != ST_IDLE) && (r_grant == c_PTR_W'(gi));
        end
    endgenerate

    assign w_cand            = ch_enable & ch_gate;
    assign w_byp_fire        = ch_enable & ~ch_gate & ~r_byp_pend & ~w_busy_mask;
    assign w_sel_addr        = w_addr[w_grant];
    assign w_unused_addr_lsb = ^w_sel_addr[1:0];
    assign w_done            = ~mem_done_n;
    assign w_timeout         = (TIMEOUT != 0) && (r_cnt == c_CNT_LAST);

    // Search upward from the channel after the last grant, wrapping at CHANNELS.
    always_comb begin
        w_found = 1'b0;
        w_grant = r_ptr;
        w_idx   = r_ptr;
        for (int k = 1; k <= CHANNELS; k++) begin
            w_idx = c_PTR_W'((int'(r_ptr) + k) % CHANNELS);
            if (!w_found && w_cand[w_idx]) begin
                w_found = 1'b1;
                w_grant = w_idx;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_found) w_state_next = ST_ACCESS;
            ST_ACCESS: if (w_done || w_timeout) w_state_next = ST_RESP;
            ST_RESP:   w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ptr         <= c_PTR_RST;
            r_grant       <= '0;
            r_cnt         <= '0;
            r_write       <= 1'b0;
            r_byp_pend    <= '0;
            r_ch_valid    <= '0;
            r_ch_error    <= '0;
            r_mem_address <= '0;
            r_mem_wdata   <= '0;
            r_read_n      <= 1'b1;
            r_write_n     <= 1'b1;
            for (int i = 0; i < CHANNELS; i++) begin
                r_ch_rdata[i] <= '0;
            end
        end else begin
            r_byp_pend <= w_byp_fire;
            r_ch_valid <= w_byp_fire;
            r_ch_error <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                if (w_byp_fire[i]) begin
                    r_ch_rdata[i] <= '0;
                end
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_grant       <= w_grant;
                        r_ptr         <= w_grant;
                        r_write       <= ch_write[w_grant];
                        r_mem_address <= {w_sel_addr[ADDR_WIDTH-1:2], 2'b00};
                        r_mem_wdata   <= w_wdata[w_grant];
                        r_read_n      <= ch_write[w_grant];
                        r_write_n     <= ~ch_write[w_grant];
                        r_cnt         <= '0;
                    end
                end
                ST_ACCESS: begin
                    if (w_done) begin
                        r_read_n            <= 1'b1;
                        r_write_n           <= 1'b1;
                        r_ch_valid[r_grant] <= 1'b1;
                        if (!r_write) begin
                            r_ch_rdata[r_grant] <= mem_read_data;
                        end
                    end else if (w_timeout) begin
                        r_read_n            <= 1'b1;
                        r_write_n           <= 1'b1;
                        r_ch_valid[r_grant] <= 1'b1;
                        r_ch_error[r_grant] <= 1'b1;
                        r_ch_rdata[r_grant] <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    r_cnt <= '0;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign ch_valid       = r_ch_valid;
    assign ch_error       = r_ch_error;
    assign mem_address    = r_mem_address;
    assign mem_write_data = r_mem_wdata;
    assign mem_read_n     = r_read_n;
    assign mem_write_n    = r_write_n;
    assign busy           = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_channel_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_channel_arbiter
// Desc     : Self-checking bench: vector table plus multi-cycle sequences,
//            completions checked against a queue of expected responses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_channel_arbiter;
    localparam int CH = 3;
    localparam int AW = 25;
    localparam int DW = 32;
    localparam int TO = 8;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [CH*AW-1:0]  ch_addr = '0;
    logic [CH-1:0]     ch_enable = '0;
    logic [CH-1:0]     ch_write = '0;
    logic [CH*DW-1:0]  ch_wdata = '0;
    logic [CH-1:0]     ch_gate = '1;
    logic [CH*DW-1:0]  ch_rdata;
    logic [CH-1:0]     ch_valid;
    logic [CH-1:0]     ch_error;
    logic [AW-1:0]     mem_address;
    logic              mem_read_n;
    logic              mem_write_n;
    logic [DW-1:0]     mem_write_data;
    logic [DW-1:0]     mem_read_data = '0;
    logic              mem_done_n = 1'b1;
    logic              busy;

    mem_channel_arbiter #(
        .CHANNELS(CH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)
    ) dut (
        .clock(clock), .reset(reset), .ch_addr(ch_addr), .ch_enable(ch_enable),
        .ch_write(ch_write), .ch_wdata(ch_wdata), .ch_gate(ch_gate),
        .ch_rdata(ch_rdata), .ch_valid(ch_valid), .ch_error(ch_error),
        .mem_address(mem_address), .mem_read_n(mem_read_n), .mem_write_n(mem_write_n),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
        .mem_done_n(mem_done_n), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          ch;
        logic [DW-1:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    typedef struct {
        int          ch;
        logic        wr;
        logic        gate;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int          lat;
        logic [DW-1:0] mval;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    exp_t sb[$];
    vec_t vt[9];
    int   compared    = 0;
    int   mismatched  = 0;
    int   completions = 0;
    int   cycle       = 0;

    // Memory model state
    int            mem_lat      = 1;
    logic [DW-1:0] mem_value    = '0;
    logic          addr_mode    = 1'b0;
    logic          force_done   = 1'b0;
    int            strobe_cnt   = 0;
    int            strobe_total = 0;
    int            last_len     = 0;
    logic          last_wr      = 1'b0;
    logic [AW-1:0] last_addr    = '0;
    logic [DW-1:0] last_wdata   = '0;
    int            m_idx;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endfunction

    function automatic void push_exp(int ch, logic [DW-1:0] rdata, logic err, int cyc);
        exp_t e;
        e.ch = ch; e.rdata = rdata; e.err = err; e.cyc = cyc;
        sb.push_back(e);
    endfunction

    always @(posedge clock) cycle <= cycle + 1;

    // Memory responder: completes after mem_lat strobe cycles (0 = never).
    always @(negedge clock) begin
        if (!mem_read_n || !mem_write_n) begin
            if (strobe_cnt == 0) begin
                last_addr  = mem_address;
                last_wr    = !mem_write_n;
                last_wdata = mem_write_data;
            end
            strobe_cnt++;
            strobe_total++;
            last_len = strobe_cnt;
            check("strobes_exclusive", 64'(!mem_read_n && !mem_write_n), 64'd0);
            if (mem_lat != 0 && strobe_cnt == mem_lat) begin
                mem_done_n    = 1'b0;
                mem_read_data = addr_mode ? (mem_value ^ {{(DW-AW){1'b0}}, mem_address}) : mem_value;
            end else begin
                mem_done_n    = 1'b1;
                mem_read_data = 32'hBAD0_BAD0;
            end
        end else begin
            strobe_cnt = 0;
            mem_done_n = force_done ? 1'b0 : 1'b1;
        end
    end

    // Completion monitor: every ch_valid bit must match a queued expectation.
    always @(negedge clock) begin
        check("error_without_valid", 64'(ch_error & ~ch_valid), 64'd0);
        for (int i = 0; i < CH; i++) begin
            if (ch_valid[i]) begin
                m_idx = -1;
                for (int k = 0; k < sb.size(); k++) begin
                    if (m_idx < 0 && sb[k].ch == i) m_idx = k;
                end
                if (m_idx < 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_valid: ch%0d pulsed at cycle %0d, none expected", i, cycle);
                end else begin
                    check($sformatf("ch%0d_rdata", i), 64'(ch_rdata[i*DW +: DW]), 64'(sb[m_idx].rdata));
                    check($sformatf("ch%0d_error", i), 64'(ch_error[i]), 64'(sb[m_idx].err));
                    check($sformatf("ch%0d_valid_cycle", i), 64'(cycle), 64'(sb[m_idx].cyc));
                    sb.delete(m_idx);
                    completions++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_until(int target, int budget, string name);
        int k;
        k = 0;
        while (completions < target && k < budget) begin
            @(negedge clock);
            #1;
            k++;
        end
        if (completions < target) begin
            compared++;
            mismatched++;
            $display("FAIL %s: %0d completions seen, %0d required within %0d cycles",
                     name, completions, target, budget);
        end
    endtask

    task automatic issue(int ch, logic wr, logic gate, logic [AW-1:0] addr, logic [DW-1:0] wd);
        ch_addr[ch*AW +: AW]  = addr;
        ch_wdata[ch*DW +: DW] = wd;
        ch_write[ch]          = wr;
        ch_gate[ch]           = gate;
        ch_enable[ch]         = 1'b1;
    endtask

    task automatic run_vec(vec_t v, string name);
        int base;
        int tot0;
        mem_lat   = v.lat;
        mem_value = v.mval;
        step();
        tot0 = strobe_total;
        base = completions;
        issue(v.ch, v.wr, v.gate, v.addr, v.wdata);
        push_exp(v.ch, v.exp_rdata, v.exp_err, cycle + v.exp_lat);
        wait_until(base + 1, 40, name);
        ch_enable = '0;
        ch_gate   = '1;
        if (v.gate) begin
            check({name, "_mem_address"}, 64'(last_addr), 64'(v.exp_addr));
            check({name, "_direction"}, 64'(last_wr), 64'(v.wr));
            check({name, "_strobe_len"}, 64'(last_len), 64'((v.lat == 0) ? TO : v.lat));
            if (v.wr) check({name, "_wdata"}, 64'(last_wdata), 64'(v.wdata));
        end else begin
            check({name, "_no_strobe"}, 64'(strobe_total), 64'(tot0));
            check({name, "_busy"}, 64'(busy), 64'd0);
        end
        repeat (2) step();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int tot0;
        int cyc0;
        //        ch wr    gate  addr           wdata          lat mval           exp_addr       exp_rdata      err   lat
        vt[0] = vec_t'{1, 1'b0, 1'b1, 25'h0000123, 32'h0,        1, 32'hDEADBEEF, 25'h0000120, 32'hDEADBEEF, 1'b0, 2};
        vt[1] = vec_t'{2, 1'b1, 1'b1, 25'h1ABCDEF, 32'h12345678, 4, 32'h0,        25'h1ABCDEC, 32'h0,        1'b0, 5};
        vt[2] = vec_t'{0, 1'b0, 1'b1, 25'h0000007, 32'h0,        2, 32'hCAFEF00D, 25'h0000004, 32'hCAFEF00D, 1'b0, 3};
        vt[3] = vec_t'{0, 1'b0, 1'b1, 25'h0000AB1, 32'h0,        0, 32'h0,        25'h0000AB0, 32'h0,        1'b1, 9};
        vt[4] = vec_t'{0, 1'b0, 1'b1, 25'h1FFFFFF, 32'h0,        1, 32'h0BADF00D, 25'h1FFFFFC, 32'h0BADF00D, 1'b0, 2};
        vt[5] = vec_t'{2, 1'b0, 1'b1, 25'h0000010, 32'h0,        3, 32'h55AA55AA, 25'h0000010, 32'h55AA55AA, 1'b0, 4};
        vt[6] = vec_t'{1, 1'b1, 1'b1, 25'h0000202, 32'hA5A5A5A5, 1, 32'h0,        25'h0000200, 32'hDEADBEEF, 1'b0, 2};
        vt[7] = vec_t'{2, 1'b0, 1'b0, 25'h0000044, 32'h0,        1, 32'h0,        25'h0,       32'h0,        1'b0, 1};
        vt[8] = vec_t'{1, 1'b1, 1'b0, 25'h0000048, 32'hFFFFFFFF, 1, 32'h0,        25'h0,       32'h0,        1'b0, 1};

        repeat (3) step();
        reset = 1'b0;
        @(negedge clock);
        check("rst_mem_read_n", 64'(mem_read_n), 64'd1);
        check("rst_mem_write_n", 64'(mem_write_n), 64'd1);
        check("rst_mem_address", 64'(mem_address), 64'd0);
        check("rst_mem_write_data", 64'(mem_write_data), 64'd0);
        check("rst_ch_rdata", 64'(ch_rdata == '0), 64'd1);
        check("rst_ch_valid", 64'(ch_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);

        for (int v = 0; v < 9; v++) begin
            run_vec(vt[v], $sformatf("vec%0d", v));
        end

        // Gate and enable dropped mid-access: the access still completes.
        mem_lat = 3; mem_value = 32'h13579BDF;
        step();
        base = completions;
        issue(0, 1'b0, 1'b1, 25'h0000040, 32'h0);
        push_exp(0, 32'h13579BDF, 1'b0, cycle + 4);
        step();
        ch_enable[0] = 1'b0;
        ch_gate[0]   = 1'b0;
        wait_until(base + 1, 20, "gate_drop");
        ch_gate = '1;
        repeat (2) step();

        // Bypass and arbitrated completion land in the same cycle.
        mem_lat = 1; mem_value = 32'h2468ACE0;
        step();
        base = completions;
        issue(1, 1'b0, 1'b1, 25'h0000080, 32'h0);
        push_exp(1, 32'h2468ACE0, 1'b0, cycle + 2);
        step();
        issue(2, 1'b0, 1'b0, 25'h0000090, 32'h0);
        push_exp(2, 32'h0, 1'b0, cycle + 1);
        wait_until(base + 2, 20, "simultaneous");
        ch_enable = '0;
        ch_gate   = '1;
        repeat (2) step();

        // mem_done_n low while idle must be ignored.
        force_done = 1'b1;
        repeat (3) begin
            step();
            @(negedge clock);
            check("done_idle_busy", 64'(busy), 64'd0);
        end
        force_done = 1'b0;
        step();
        run_vec(vec_t'{2, 1'b0, 1'b1, 25'h0000333, 32'h0, 2, 32'h0F0F0F0F,
                       25'h0000330, 32'h0F0F0F0F, 1'b0, 3}, "after_idle_done");

        // Bypass with enable held six cycles: pulses every second cycle.
        step();
        base = completions;
        tot0 = strobe_total;
        cyc0 = cycle;
        issue(0, 1'b0, 1'b0, 25'h0000050, 32'h0);
        push_exp(0, 32'h0, 1'b0, cyc0 + 1);
        push_exp(0, 32'h0, 1'b0, cyc0 + 3);
        push_exp(0, 32'h0, 1'b0, cyc0 + 5);
        repeat (6) begin
            @(negedge clock);
            check("bypass_busy", 64'(busy), 64'd0);
            @(posedge clock);
            #1;
        end
        ch_enable = '0;
        ch_gate   = '1;
        repeat (3) step();
        check("bypass_pulse_count", 64'(completions - base), 64'd3);
        check("bypass_no_strobe", 64'(strobe_total), 64'(tot0));

        // Reset during the second ACCESS cycle of a read.
        mem_lat = 0;
        step();
        issue(1, 1'b0, 1'b1, 25'h0000055, 32'h0);
        step();
        step();
        reset = 1'b1;
        step();
        reset     = 1'b0;
        ch_enable = '0;
        @(negedge clock);
        check("midrst_read_n", 64'(mem_read_n), 64'd1);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_valid", 64'(ch_valid), 64'd0);
        check("midrst_rdata", 64'(ch_rdata == '0), 64'd1);
        repeat (2) step();

        // Round robin: three channels requesting continuously from reset.
        mem_lat = 1; mem_value = 32'hC0DE0000; addr_mode = 1'b1;
        step();
        base = completions;
        cyc0 = cycle;
        issue(0, 1'b0, 1'b1, 25'h0000100, 32'h0);
        issue(1, 1'b0, 1'b1, 25'h0000204, 32'h0);
        issue(2, 1'b0, 1'b1, 25'h0000308, 32'h0);
        for (int r = 0; r < 6; r++) begin
            push_exp(r % 3, 32'hC0DE0000 ^ (32'h100 * (r % 3 + 1) + 32'h4 * (r % 3)), 1'b0, cyc0 + 2 + 3 * r);
        end
        wait_until(base + 6, 60, "round_robin");
        ch_enable = '0;
        addr_mode = 1'b0;
        repeat (5) step();

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_channel_arbiter.md
Name: mem_channel_arbiter

Overview:
- N-channel request arbiter between the core's memory request channels (instruction fetch, data read, data write, future DMA) and one external memory port with active-low strobes.
- Replaces the fixed three-channel glue at the top level: channel count, widths and per-channel gating are parameters or inputs.
- Adds round-robin arbitration, registered responses and a timeout/error path.
- Sits between the core and the system interconnect.

Parameters:
- CHANNELS, 3, number of requesting channels (2..8).
- ADDR_WIDTH, 25, byte address width.
- DATA_WIDTH, 32, data word width.
- TIMEOUT, 255, max cycles in ACCESS before an error completion; 0 disables the timeout.

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- ch_addr  in  CHANNELS*ADDR_WIDTH  per-channel byte address; channel i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- ch_enable  in  CHANNELS  request; held until ch_valid.
- ch_write  in  CHANNELS  1 = write, 0 = read.
- ch_wdata  in  CHANNELS*DATA_WIDTH  write data.
- ch_gate  in  CHANNELS  1 = route to memory, 0 = bypass (read data 0, writes dropped).
- ch_rdata  out  CHANNELS*DATA_WIDTH  registered read data per channel.
- ch_valid  out  CHANNELS  one-cycle completion pulse.
- ch_error  out  CHANNELS  qualifies ch_valid on timeout.
- mem_address  out  ADDR_WIDTH  word-aligned address.
- mem_read_n  out  1  active-low read strobe.
- mem_write_n  out  1  active-low write strobe.
- mem_write_data  out  DATA_WIDTH.
- mem_read_data  in  DATA_WIDTH.
- mem_done_n  in  1  active-low read-data-ready / write-done.
- busy  out  1  FSM not in IDLE.

Behaviour:
Reset:
- All outputs return to reset values at the next clock edge: mem_read_n=1, mem_write_n=1, mem_address=0, mem_write_data=0, ch_rdata=0, ch_valid=0, ch_error=0, busy=0.
- Round-robin pointer resets to CHANNELS-1, so channel 0 has first priority.
- Reset mid-access drops the strobes at the next edge and produces no ch_valid.

FSM states: IDLE, ACCESS, RESP.
- IDLE: candidates = ch_enable & ch_gate. If any candidate exists, grant the first set bit searching upward from pointer+1 (modulo CHANNELS).
  - Register mem_address = {addr[ADDR_WIDTH-1:2], 2'b00}, mem_write_data and the direction.
  - Update pointer to the granted channel; go to ACCESS.
- ACCESS: mem_read_n or mem_write_n is low, per direction; never both. Timeout counter increments each cycle.
  - mem_done_n sampled low: capture mem_read_data into that channel's ch_rdata (reads only), deassert the strobe, go to RESP.
  - Counter reaches TIMEOUT with no done: deassert the strobe, set ch_rdata=0 and the channel's error flag, go to RESP.
- RESP: ch_valid[grant]=1 (with ch_error if flagged) for exactly one cycle; clear the counter; go to IDLE.

Latency and throughput:
- Minimum latency is 2 cycles: request visible in cycle 0, strobe in cycle 1, done in cycle 1, ch_valid in cycle 2.
- Minimum occupancy is 3 cycles per access.

Bypass (gate=0):
- Independent of the FSM. ch_valid pulses the cycle after enable is sampled, with ch_rdata=0 and ch_error=0.
- If enable is held, it pulses every second cycle.
- Never touches the memory port.

Boundaries:
- Gate and direction are sampled at grant only. A gate drop or enable drop mid-access does not abort; the access completes and ch_valid still pulses.
- Simultaneous bypass and arbitrated completion on different channels are both reported in the same cycle.
- mem_done_n low outside ACCESS is ignored.
- Low address bits [1:0] are discarded.
- Pointer wraps from CHANNELS-1 to 0.
- With TIMEOUT=0 the arbiter waits indefinitely.

Test Plan:
1. Single read, ch1 gated, addr 0x0000123, memory returns 0xDEADBEEF on its first strobe cycle -> mem_address=0x0000120, mem_read_n low 1 cycle, ch_valid[1] in cycle 2, ch_rdata[1]=0xDEADBEEF, ch_error=0.
2. Channels 0, 1, 2 request continuously, 1-cycle memory -> grant order 0,1,2,0,1,2; each ch_valid separated by 3 cycles; no channel is granted twice before the others are served.
3. Write on ch2, wdata 0x12345678, memory done after 4 cycles -> mem_write_n low for exactly 4 cycles, mem_read_n stays 1, ch_valid[2] one cycle later, ch_rdata[2] unchanged.
4. TIMEOUT=8, mem_done_n held high -> strobe low for 8 cycles then high, ch_valid[0]=ch_error[0]=1 for one cycle, ch_rdata[0]=0, next request is accepted normally.
5. ch_gate=0 on ch0, enable held 6 cycles -> ch_valid[0] pulses in cycles 1, 3, 5 with data 0, memory strobes never asserted, busy=0.
6. Reset asserted in the 2nd ACCESS cycle of a read -> mem_read_n=1 and busy=0 next cycle, no ch_valid, first grant after reset goes to ch0.
